// File: rtl/wr_regfile_pkg.sv
// Shared definitions for the write-back stage: default widths, the
// hardwired-zero register number and the write-back select encoding used by
// the control unit, the MEM/WR pipeline register and the register file.
package wr_regfile_pkg;

   localparam int DW_DEF   = 32;
   localparam int AW_DEF   = 5;
   localparam int REG_ZERO = 0;

   // Write-back source select: MEM picks load data, ALU picks the ALU result.
   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_sel_e;

endpackage

// File: rtl/wr_regfile_if.sv
// Bus between the MEM/WR pipeline register / ID stage (master) and the
// write-back register file (slave). Carries the WR-stage bundle, both read
// ports and the exported write-back value used for forwarding.
interface wr_regfile_if
   import wr_regfile_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) ();

   logic [DW-1:0] WR_Dout;
   logic [DW-1:0] WR_ALUout;
   logic [AW-1:0] WR_Rw;
   logic          WR_Overflow;
   logic          WR_MemtoReg;
   logic          WR_RegWr;
   logic [AW-1:0] Ra;
   logic [AW-1:0] Rb;
   logic [DW-1:0] BusA;
   logic [DW-1:0] BusB;
   logic [DW-1:0] BusW;

   modport master (
      output WR_Dout, WR_ALUout, WR_Rw, WR_Overflow, WR_MemtoReg, WR_RegWr,
      output Ra, Rb,
      input  BusA, BusB, BusW
   );

   modport slave (
      input  WR_Dout, WR_ALUout, WR_Rw, WR_Overflow, WR_MemtoReg, WR_RegWr,
      input  Ra, Rb,
      output BusA, BusB, BusW
   );

endinterface

// File: rtl/wr_regfile_wbmux.sv
// Write-back select and commit qualification. Picks load data or the ALU
// result and decides whether the instruction really commits: a write needs a
// request, no ALU overflow and a non-zero destination. Also shared with the
// forwarding unit so both agree on what actually gets written.
module wr_wbmux
   import wr_regfile_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic [DW-1:0] dout_i,
   input  logic [DW-1:0] aluout_i,
   input  logic [AW-1:0] rw_i,
   input  logic          overflow_i,
   input  logic          memtoreg_i,
   input  logic          regwr_i,
   output logic [DW-1:0] busW_o,
   output logic          we_o,
   output logic          ovfHit_o
);

   wb_sel_e wbSel;

   assign wbSel = wb_sel_e'(memtoreg_i);

   // Write-back value is always driven, whether or not the write commits,
   // so forwarding logic can use it unconditionally.
   always_comb begin
      busW_o = aluout_i;
      if (wbSel == WB_MEM) begin
         busW_o = dout_i;
      end
   end

   // Commit only real writes; an overflowing write is reported separately so
   // the register file can raise its sticky flag.
   always_comb begin
      we_o     = regwr_i & ~overflow_i & (rw_i != AW'(REG_ZERO));
      ovfHit_o = regwr_i & overflow_i;
   end

endmodule

// File: rtl/wr_regfile.sv
// Write-back stage register file: 2**AW x DW array with register 0 hardwired
// to zero, two combinational read ports, a committed-write counter and a
// sticky flag for overflow-suppressed writes.
// Optional build macro REGFILE_BYPASS_EN: forwards the committing value to a
// read port in the same cycle when the addresses match.
module wr_regfile
   import wr_regfile_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic        Clk,
   input  logic        Clrn,
   wr_regfile_if.slave bus,
   output logic [31:0] WrCount,
   output logic        OvfSticky
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] regs_q [DEPTH];
   logic [31:0]   wrCount_q;
   logic [31:0]   wrCount_d;
   logic          ovfSticky_q;
   logic          ovfSticky_d;
   logic [DW-1:0] busW;
   logic          we;
   logic          ovfHit;
   logic [DW-1:0] busA;
   logic [DW-1:0] busB;

   wr_wbmux #(
      .DW (DW),
      .AW (AW)
   ) u_wbmux (
      .dout_i     (bus.WR_Dout),
      .aluout_i   (bus.WR_ALUout),
      .rw_i       (bus.WR_Rw),
      .overflow_i (bus.WR_Overflow),
      .memtoreg_i (bus.WR_MemtoReg),
      .regwr_i    (bus.WR_RegWr),
      .busW_o     (busW),
      .we_o       (we),
      .ovfHit_o   (ovfHit)
   );

   assign bus.BusW  = busW;
   assign bus.BusA  = busA;
   assign bus.BusB  = busB;
   assign WrCount   = wrCount_q;
   assign OvfSticky = ovfSticky_q;

   // Register array: cleared on reset, written with the selected value on a
   // qualified commit. Entry 0 is never written because we excludes it.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we) begin
         regs_q[bus.WR_Rw] <= busW;
      end
   end

   // Debug state next values: count each commit (wrapping naturally) and
   // latch any overflow-suppressed write until reset.
   always_comb begin
      wrCount_d   = wrCount_q;
      ovfSticky_d = ovfSticky_q | ovfHit;
      if (we) begin
         wrCount_d = wrCount_q + 32'd1;
      end
   end

   // Debug state registers.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         wrCount_q   <= '0;
         ovfSticky_q <= 1'b0;
      end else begin
         wrCount_q   <= wrCount_d;
         ovfSticky_q <= ovfSticky_d;
      end
   end

   // Read port A: register 0 always reads zero; the optional bypass is held
   // off during reset so the ports read zero while Clrn is low.
   always_comb begin
      busA = '0;
      if (bus.Ra != AW'(REG_ZERO)) begin
         busA = regs_q[bus.Ra];
      end
`ifdef REGFILE_BYPASS_EN
      if (Clrn && we && (bus.Ra == bus.WR_Rw)) begin
         busA = busW;
      end
`endif
   end

   // Read port B: same rules as port A.
   always_comb begin
      busB = '0;
      if (bus.Rb != AW'(REG_ZERO)) begin
         busB = regs_q[bus.Rb];
      end
`ifdef REGFILE_BYPASS_EN
      if (Clrn && we && (bus.Rb == bus.WR_Rw)) begin
         busB = busW;
      end
`endif
   end

endmodule

// File: tb/tb_wr_regfile.sv
// Directed testbench for wr_regfile. Inputs change on the falling edge like
// the MEM/WR register; outputs are sampled 1 time unit after the rising edge
// or in the low half of the cycle. Build with or without REGFILE_BYPASS_EN.
module tb_wr_regfile;

   logic        Clk;
   logic        Clrn;
   logic [31:0] WrCount;
   logic        OvfSticky;

   int checks;
   int errors;
   logic [31:0] expCount;

   wr_regfile_if #(.DW(32), .AW(5)) bus ();

   wr_regfile #(.DW(32), .AW(5)) dut (
      .Clk       (Clk),
      .Clrn      (Clrn),
      .bus       (bus.slave),
      .WrCount   (WrCount),
      .OvfSticky (OvfSticky)
   );

   // Free-running pipeline clock.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // One committed-or-suppressed write: drive on the falling edge, let the
   // rising edge act, then drop the request just after it.
   task automatic wrCycle(input logic [4:0] rw, input logic [31:0] alu,
                          input logic [31:0] dout, input logic memToReg,
                          input logic ovf);
      @(negedge Clk);
      bus.WR_Rw       = rw;
      bus.WR_ALUout   = alu;
      bus.WR_Dout     = dout;
      bus.WR_MemtoReg = memToReg;
      bus.WR_Overflow = ovf;
      bus.WR_RegWr    = 1'b1;
      @(posedge Clk);
      #1;
      bus.WR_RegWr    = 1'b0;
      bus.WR_Overflow = 1'b0;
   endtask

   // Reset behaviour: state clear, reads zero, BusW live, release mid-cycle.
   task automatic test_reset();
      #1;
      checks++;
      if (WrCount !== 32'd0) begin
         errors++; $display("[TB] FAIL reset_count: got %h expected %h", WrCount, 32'd0);
      end
      checks++;
      if (OvfSticky !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_ovf: got %b expected %b", OvfSticky, 1'b0);
      end
      // A write request held during reset must not commit or bypass.
      @(negedge Clk);
      bus.Ra = 5'd7;
      bus.WR_Rw = 5'd7; bus.WR_ALUout = 32'h77; bus.WR_MemtoReg = 1'b0; bus.WR_RegWr = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if (bus.BusA !== 32'd0) begin
         errors++; $display("[TB] FAIL reset_no_commit: got %h expected %h", bus.BusA, 32'd0);
      end
      #2 Clrn = 1'b1;
      @(posedge Clk); #1;
      bus.WR_RegWr = 1'b0;
      expCount = 32'd1;
      checks++;
      if (bus.BusA !== 32'h77) begin
         errors++; $display("[TB] FAIL first_commit_data: got %h expected %h", bus.BusA, 32'h77);
      end
      checks++;
      if (WrCount !== expCount) begin
         errors++; $display("[TB] FAIL first_commit_count: got %h expected %h", WrCount, expCount);
      end
      // Load every register, plus one suppressed write to raise the flag.
      for (int i = 1; i < 32; i++) begin
         wrCycle(5'(i), 32'h100 + 32'(i), 32'h0, 1'b0, 1'b0);
         expCount++;
      end
      wrCycle(5'd4, 32'hBAD, 32'h0, 1'b0, 1'b1);
      bus.Ra = 5'd31; bus.Rb = 5'd1;
      #1;
      checks++;
      if (bus.BusA !== 32'h11F || bus.BusB !== 32'h101) begin
         errors++; $display("[TB] FAIL load_read: got %h/%h expected %h/%h", bus.BusA, bus.BusB, 32'h11F, 32'h101);
      end
      checks++;
      if (WrCount !== expCount || OvfSticky !== 1'b1) begin
         errors++; $display("[TB] FAIL load_state: got %h/%b expected %h/%b", WrCount, OvfSticky, expCount, 1'b1);
      end
      // Asynchronous reset pulse in the middle of the low phase.
      @(negedge Clk);
      bus.WR_ALUout = 32'h55; bus.WR_MemtoReg = 1'b0;
      #2 Clrn = 1'b0;
      #1;
      checks++;
      if (WrCount !== 32'd0 || OvfSticky !== 1'b0) begin
         errors++; $display("[TB] FAIL pulse_state: got %h/%b expected %h/%b", WrCount, OvfSticky, 32'd0, 1'b0);
      end
      checks++;
      if (bus.BusA !== 32'd0 || bus.BusB !== 32'd0) begin
         errors++; $display("[TB] FAIL pulse_read: got %h/%h expected 0/0", bus.BusA, bus.BusB);
      end
      checks++;
      if (bus.BusW !== 32'h55) begin
         errors++; $display("[TB] FAIL pulse_busw: got %h expected %h", bus.BusW, 32'h55);
      end
      for (int i = 1; i < 32; i++) begin
         bus.Ra = 5'(i);
         #1;
         checks++;
         if (bus.BusA !== 32'd0) begin
            errors++; $display("[TB] FAIL pulse_reg%0d: got %h expected %h", i, bus.BusA, 32'd0);
         end
      end
      @(negedge Clk);
      #2 Clrn = 1'b1;
      expCount = 32'd0;
   endtask

   // Write-back select between ALU result and load data.
   task automatic test_write_select();
      bus.Ra = 5'd5;
      wrCycle(5'd5, 32'h1234, 32'hCAFE, 1'b0, 1'b0);
      expCount++;
      checks++;
      if (bus.BusA !== 32'h1234) begin
         errors++; $display("[TB] FAIL sel_alu: got %h expected %h", bus.BusA, 32'h1234);
      end
      wrCycle(5'd5, 32'h9999, 32'hDEADBEEF, 1'b1, 1'b0);
      expCount++;
      checks++;
      if (bus.BusA !== 32'hDEADBEEF) begin
         errors++; $display("[TB] FAIL sel_mem: got %h expected %h", bus.BusA, 32'hDEADBEEF);
      end
      checks++;
      if (WrCount !== 32'd2) begin
         errors++; $display("[TB] FAIL sel_count: got %h expected %h", WrCount, 32'd2);
      end
   endtask

   // Register 0 is never written, never counted and always reads zero.
   task automatic test_reg_zero();
      @(negedge Clk);
      bus.Ra = 5'd0; bus.Rb = 5'd0;
      bus.WR_Rw = 5'd0; bus.WR_ALUout = 32'hFFFFFFFF; bus.WR_MemtoReg = 1'b0; bus.WR_RegWr = 1'b1;
      #1;
      checks++;
      if (bus.BusA !== 32'd0 || bus.BusB !== 32'd0) begin
         errors++; $display("[TB] FAIL zero_prebypass: got %h/%h expected 0/0", bus.BusA, bus.BusB);
      end
      @(posedge Clk); #1;
      bus.WR_RegWr = 1'b0;
      checks++;
      if (bus.BusA !== 32'd0) begin
         errors++; $display("[TB] FAIL zero_read: got %h expected %h", bus.BusA, 32'd0);
      end
      checks++;
      if (WrCount !== expCount) begin
         errors++; $display("[TB] FAIL zero_count: got %h expected %h", WrCount, expCount);
      end
   endtask

   // Overflow suppresses the write and count, sets the sticky flag.
   task automatic test_overflow();
      bus.Ra = 5'd3;
      wrCycle(5'd3, 32'h7, 32'h0, 1'b0, 1'b0);
      expCount++;
      @(negedge Clk);
      bus.WR_Rw = 5'd3; bus.WR_ALUout = 32'h80000000; bus.WR_MemtoReg = 1'b0;
      bus.WR_Overflow = 1'b1; bus.WR_RegWr = 1'b1;
      #1;
      checks++;
      if (bus.BusA !== 32'h7) begin
         errors++; $display("[TB] FAIL ovf_no_bypass: got %h expected %h", bus.BusA, 32'h7);
      end
      @(posedge Clk); #1;
      bus.WR_RegWr = 1'b0; bus.WR_Overflow = 1'b0;
      checks++;
      if (bus.BusA !== 32'h7) begin
         errors++; $display("[TB] FAIL ovf_reg: got %h expected %h", bus.BusA, 32'h7);
      end
      checks++;
      if (OvfSticky !== 1'b1 || WrCount !== expCount) begin
         errors++; $display("[TB] FAIL ovf_state: got %b/%h expected %b/%h", OvfSticky, WrCount, 1'b1, expCount);
      end
      wrCycle(5'd6, 32'h66, 32'h0, 1'b0, 1'b0);
      expCount++;
      checks++;
      if (OvfSticky !== 1'b1 || WrCount !== expCount) begin
         errors++; $display("[TB] FAIL ovf_sticky: got %b/%h expected %b/%h", OvfSticky, WrCount, 1'b1, expCount);
      end
   endtask

   // Same-cycle read of the register being written, on both ports.
   task automatic test_bypass();
      logic [31:0] expPre;
      wrCycle(5'd9, 32'h11111111, 32'h0, 1'b0, 1'b0);
      expCount++;
`ifdef REGFILE_BYPASS_EN
      expPre = 32'hA5A5A5A5;
`else
      expPre = 32'h11111111;
`endif
      @(negedge Clk);
      bus.Ra = 5'd9; bus.Rb = 5'd9;
      bus.WR_Rw = 5'd9; bus.WR_ALUout = 32'hA5A5A5A5; bus.WR_MemtoReg = 1'b0; bus.WR_RegWr = 1'b1;
      #1;
      checks++;
      if (bus.BusA !== expPre || bus.BusB !== expPre) begin
         errors++; $display("[TB] FAIL bypass_pre: got %h/%h expected %h", bus.BusA, bus.BusB, expPre);
      end
      @(posedge Clk); #1;
      bus.WR_RegWr = 1'b0;
      expCount++;
      #1;
      checks++;
      if (bus.BusA !== 32'hA5A5A5A5 || bus.BusB !== 32'hA5A5A5A5) begin
         errors++; $display("[TB] FAIL bypass_post: got %h/%h expected %h", bus.BusA, bus.BusB, 32'hA5A5A5A5);
      end
   endtask

   // Consecutive writes to one register: last wins, each counts.
   task automatic test_back_to_back();
      bus.Ra = 5'd12;
      @(negedge Clk);
      bus.WR_Rw = 5'd12; bus.WR_ALUout = 32'h1; bus.WR_MemtoReg = 1'b0; bus.WR_RegWr = 1'b1;
      @(negedge Clk);
      bus.WR_ALUout = 32'h2;
      @(posedge Clk); #1;
      bus.WR_RegWr = 1'b0;
      expCount = expCount + 32'd2;
      checks++;
      if (bus.BusA !== 32'h2) begin
         errors++; $display("[TB] FAIL b2b_data: got %h expected %h", bus.BusA, 32'h2);
      end
      checks++;
      if (WrCount !== expCount) begin
         errors++; $display("[TB] FAIL b2b_count: got %h expected %h", WrCount, expCount);
      end
   endtask

   // Counter wrap through 0xFFFFFFFF.
   task automatic test_wrap();
      logic [31:0] expWrap [3];
      expWrap[0] = 32'hFFFFFFFF; expWrap[1] = 32'h0; expWrap[2] = 32'h1;
      @(negedge Clk);
      force dut.wrCount_q = 32'hFFFFFFFE;
      #1 release dut.wrCount_q;
      #1;
      checks++;
      if (WrCount !== 32'hFFFFFFFE) begin
         errors++; $display("[TB] FAIL wrap_preload: got %h expected %h", WrCount, 32'hFFFFFFFE);
      end
      for (int i = 0; i < 3; i++) begin
         wrCycle(5'(20 + i), 32'(i), 32'h0, 1'b0, 1'b0);
         checks++;
         if (WrCount !== expWrap[i]) begin
            errors++; $display("[TB] FAIL wrap_step%0d: got %h expected %h", i, WrCount, expWrap[i]);
         end
      end
      checks++;
      if (OvfSticky !== 1'b1) begin
         errors++; $display("[TB] FAIL wrap_ovf: got %b expected %b", OvfSticky, 1'b1);
      end
   endtask

   // Test sequence.
   initial begin
      checks = 0;
      errors = 0;
      expCount = 32'd0;
      Clrn = 1'b0;
      bus.WR_Dout = '0; bus.WR_ALUout = '0; bus.WR_Rw = '0;
      bus.WR_Overflow = 1'b0; bus.WR_MemtoReg = 1'b0; bus.WR_RegWr = 1'b0;
      bus.Ra = '0; bus.Rb = '0;
      $display("[TB] starting wr_regfile tests");
      test_reset();
      test_write_select();
      test_reg_zero();
      test_overflow();
      test_bypass();
      test_back_to_back();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
